// File: rtl/hps_fpga_pwm_pio.sv
// hps_fpga_pwm_pio
//   Avalon-MM output PIO behind the HPS lightweight bridge. Each of WIDTH
//   channels is either a static level (DATA bit) or a PWM output gated by its
//   DATA bit. All channels share one prescaled PWM counter. Duty updates are
//   double-buffered and only take effect at a PWM period boundary (wrap),
//   so the waveform never glitches mid-period.
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   address[2:0]        register word address
//   chipselect, write_n write strobe = chipselect & ~write_n
//   writedata[31:0]     write data
//   readdata[31:0]      combinational read data, zero wait states
//   out_port[WIDTH-1:0] registered channel outputs

// Per-channel duty double buffer and output select.
module hps_fpga_pwm_pio_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                duty_we,
  input  logic [PWM_BITS:0]   duty_wd,
  input  logic                wrap,
  input  logic                data_bit,
  input  logic                mode_bit,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS:0]   shadow,
  output logic                pending,
  output logic                next_out
);
  logic [PWM_BITS:0] active;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (duty_we && wrap) begin
      // Write lands exactly on the boundary: apply it now, nothing left pending.
      shadow  <= duty_wd;
      active  <= duty_wd;
      pending <= 1'b0;
    end else if (duty_we) begin
      shadow  <= duty_wd;
      pending <= 1'b1;
    end else if (wrap) begin
      if (pending) active <= shadow;
      pending <= 1'b0;
    end
  end

  // Compare one bit wider than the counter so duty >= 2^PWM_BITS is always on.
  assign next_out = mode_bit ? (data_bit & ({1'b0, pwm_cnt} < active)) : data_bit;
endmodule

module hps_fpga_pwm_pio #(
  parameter int WIDTH         = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  localparam logic [2:0] A_DATA = 3'd0, A_OUTSET = 3'd1, A_OUTCLR = 3'd2,
                         A_MODE = 3'd3, A_PRESCALE = 3'd4, A_DUTY_SEL = 3'd5,
                         A_DUTY = 3'd6, A_STATUS = 3'd7;

  logic                          wr;
  logic [WIDTH-1:0]              data, mode;
  logic [PRESCALE_BITS-1:0]      prescale, presc_cnt;
  logic [4:0]                    duty_sel;
  logic [PWM_BITS-1:0]           pwm_cnt;
  logic                          tick, wrap, wrap_flag;
  logic [WIDTH-1:0][PWM_BITS:0]  shadow_all;
  logic [WIDTH-1:0]              pending_all, next_out;
  logic                          unused_wd;

  assign wr        = chipselect & ~write_n;
  assign tick      = (presc_cnt == prescale);
  assign wrap      = tick & (pwm_cnt == '1);
  assign unused_wd = ^writedata;

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= '0;
      mode     <= '0;
      prescale <= '0;
      duty_sel <= '0;
    end else if (wr) begin
      case (address)
        A_DATA:     data     <= writedata[WIDTH-1:0];
        A_OUTSET:   data     <= data | writedata[WIDTH-1:0];
        A_OUTCLR:   data     <= data & ~writedata[WIDTH-1:0];
        A_MODE:     mode     <= writedata[WIDTH-1:0];
        A_PRESCALE: prescale <= writedata[PRESCALE_BITS-1:0];
        A_DUTY_SEL: duty_sel <= writedata[4:0];
        default: ;
      endcase
    end
  end

  // Prescaler and PWM counter. A PRESCALE write restarts the prescaler so a
  // shrunken terminal count can never be skipped over.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      if (wr && address == A_PRESCALE) presc_cnt <= '0;
      else if (tick)                   presc_cnt <= '0;
      else                             presc_cnt <= presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Sticky WRAP; a wrap in the same cycle as the clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)                                        wrap_flag <= 1'b0;
    else if (wrap)                                    wrap_flag <= 1'b1;
    else if (wr && address == A_STATUS && writedata[0]) wrap_flag <= 1'b0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    // duty_sel >= WIDTH matches no lane, so such writes are dropped.
    hps_fpga_pwm_pio_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .duty_we  (wr && address == A_DUTY && duty_sel == 5'(i)),
      .duty_wd  (writedata[PWM_BITS:0]),
      .wrap     (wrap),
      .data_bit (data[i]),
      .mode_bit (mode[i]),
      .pwm_cnt  (pwm_cnt),
      .shadow   (shadow_all[i]),
      .pending  (pending_all[i]),
      .next_out (next_out[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) out_port <= '0;
    else       out_port <= next_out;
  end

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:     readdata[WIDTH-1:0]         = data;
      A_MODE:     readdata[WIDTH-1:0]         = mode;
      A_PRESCALE: readdata[PRESCALE_BITS-1:0] = prescale;
      A_DUTY_SEL: readdata[4:0]               = duty_sel;
      A_DUTY: begin
        for (int i = 0; i < WIDTH; i++)
          if (duty_sel == 5'(i)) readdata[PWM_BITS:0] = shadow_all[i];
      end
      A_STATUS: begin
        readdata[0] = wrap_flag;
        readdata[1] = |pending_all;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_hps_fpga_pwm_pio.sv
// Directed bench for hps_fpga_pwm_pio (WIDTH=8, PWM_BITS=8, PRESCALE_BITS=16).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_hps_fpga_pwm_pio;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic [7:0]  out_port;
  int          n_chk = 0, n_fail = 0;
  int          n;

  hps_fpga_pwm_pio #(.WIDTH(8), .PWM_BITS(8), .PRESCALE_BITS(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle bus write, captured at the next edge; returns at edge+1ns.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a; #1;
    chk(tag, readdata, exp);
  endtask

  task automatic rd_bit(input int b, input logic exp, input string tag);
    address = 3'd7; #1;
    chk(tag, 32'(readdata[b]), 32'(exp));
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Clear WRAP then return 1ns after the edge on which the next wrap lands.
  task automatic wait_wrap(input string tag);
    bit seen = 1'b0;
    wr(3'd7, 32'h1);
    address = 3'd7;
    for (int i = 0; i < 1200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = readdata[0];
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic count_hi(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(posedge clk); #1;
      cnt += int'(out_port[0]);
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    // 1 reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out", 32'(out_port), 32'h0);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));

    // 2 static set/clear and output latency
    step(1);
    wr(3'd0, 32'h0F);
    wr(3'd1, 32'hF0);
    wr(3'd2, 32'h81);
    chk("out_lat1", 32'(out_port), 32'hFF);
    step(1);
    chk("out_lat2", 32'(out_port), 32'h7E);
    rd(3'd0, 32'h7E, "data_rd");
    rd(3'd1, 32'h0, "outset_rd");
    rd(3'd2, 32'h0, "outclr_rd");
    wr(3'd0, 32'hFFFF_FF00);
    rd(3'd0, 32'h0, "data_upper");

    // 3 PWM duty 64
    wr(3'd0, 32'h1); wr(3'd3, 32'h1); wr(3'd4, 32'h0); wr(3'd5, 32'h0); wr(3'd6, 32'd64);
    rd(3'd6, 32'd64, "duty_rd");
    rd(3'd3, 32'h1, "mode_rd");
    wait_wrap("wrap3");
    count_hi(256, n);
    chk("pwm64", 32'(n), 32'd64);

    // 4 shadow update mid-period (now on a wrap edge)
    step(100);
    wr(3'd6, 32'd200);
    rd(3'd6, 32'd200, "shadow_rd");
    rd(3'd7, 32'h3, "pending1");
    count_hi(155, n);
    chk("old_duty_tail", 32'(n), 32'd0);
    rd(3'd7, 32'h1, "pending0");
    count_hi(256, n);
    chk("pwm200", 32'(n), 32'd200);

    // 5 duty edges and out-of-range select
    wr(3'd6, 32'd0);
    wait_wrap("wrap5a");
    count_hi(256, n);
    chk("duty0", 32'(n), 32'd0);
    wr(3'd6, 32'd256);
    wait_wrap("wrap5b");
    count_hi(256, n);
    chk("duty256", 32'(n), 32'd256);
    wr(3'd5, 32'd9);
    wr(3'd6, 32'd50);
    rd(3'd6, 32'h0, "sel9_rd");
    rd(3'd5, 32'd9, "sel_rd");
    rd_bit(1, 1'b0, "pend_ign");
    wr(3'd5, 32'd0);
    rd(3'd6, 32'd256, "sel_ign");

    // 6 STATUS behaviour
    wait_wrap("wrap6");
    wr(3'd7, 32'h1);
    rd_bit(0, 1'b0, "w1c");
    step(254);
    rd_bit(0, 1'b0, "wrap_early");
    wr(3'd7, 32'h1);                    // lands on the wrap edge
    rd_bit(0, 1'b1, "clr_on_wrap");
    step(255);
    wr(3'd6, 32'd32);                   // duty write on the wrap edge
    rd_bit(1, 1'b0, "pend_coinc");
    rd(3'd6, 32'd32, "duty_coinc");
    count_hi(256, n);
    chk("pwm32_coinc", 32'(n), 32'd32);

    // prescaler: PRESCALE=1 doubles the period
    wr(3'd4, 32'h1);
    rd(3'd4, 32'h1, "presc_rd");
    wr(3'd6, 32'd64);
    wait_wrap("wrap_presc");
    count_hi(512, n);
    chk("pwm64_presc1", 32'(n), 32'd128);

    // reset mid-period with a pending shadow
    wr(3'd0, 32'hFF);
    wr(3'd6, 32'd100);
    chk("pre_rst_out", 32'(out_port[7:1]), 32'h7F);
    reset = 1'b1;
    step(1);
    chk("rst2_out", 32'(out_port), 32'h0);
    reset = 1'b0;
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst2_reg%0d", a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
